// File: rtl/aes256_inv_key_sched.sv
// AES-256 decryption-side key schedule sequencer.
// Takes the final expanded-key window K7 = w[56..63] and walks the schedule
// backwards through one 256-bit window, streaming rk14..rk0 over valid/yumi.
// Optional build macro AES_INV_KEY_EQINV_EN: rk1..rk13 are passed through
// InvMixColumns for the equivalent inverse cipher.

// Forward AES S-box over NBYTES bytes, computed as GF(2^8) inverse + affine map.
module sub_bytes #(
  parameter int unsigned NBYTES = 4
) (
  input  logic [8*NBYTES-1:0] data_i,
  output logic [8*NBYTES-1:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0), then the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise substitution.
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
    end
  end

endmodule

module aes256_inv_key_sched (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         key_v_i,
  output logic         key_ready_o,
  input  logic [0:255] key_i,
  output logic         rk_v_o,
  output logic [0:127] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_last_o,
  input  logic         rk_yumi_i
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT_HI,
    CALC_A,
    CALC_B,
    EMIT_LO
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [8];
  logic [31:0] win_d [8];
  logic [2:0]  r_q, r_d;
  logic [3:0]  idx_q, idx_d;
  logic [127:0] raw_rk;
  logic [31:0] sub_a;
  logic [31:0] sub_b;
  logic [31:0] rcon;

  // SubWord(o3) feeds n4 in CALC_A; SubWord(RotWord(n7)) feeds n0 in CALC_B.
  sub_bytes #(.NBYTES(4)) u_sub_a (
    .data_i (win_q[3]),
    .data_o (sub_a)
  );

  sub_bytes #(.NBYTES(4)) u_sub_b (
    .data_i ({win_q[7][23:0], win_q[7][31:24]}),
    .data_o (sub_b)
  );

  assign rcon = 32'h0100_0000 << (r_q - 3'd1);

  // State, window, round counter and index registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      r_q     <= 3'd7;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
    end
  end

  // Back-step is split in two: CALC_A rewrites w1..w7 in place (w0 kept as o0),
  // CALC_B then derives n0 from o0 and the freshly written n7.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    r_d         = r_q;
    idx_d       = idx_q;
    key_ready_o = 1'b0;
    rk_v_o      = 1'b0;
    rk_last_o   = 1'b0;
    raw_rk      = '0;
    case (state_q)
      IDLE: begin
        key_ready_o = 1'b1;
        if (key_v_i) begin
          for (int unsigned j = 0; j < 8; j++) begin
            win_d[j] = key_i[32*j +: 32];
          end
          r_d     = 3'd7;
          idx_d   = 4'd14;
          state_d = EMIT_HI;
        end
      end
      EMIT_HI: begin
        rk_v_o = 1'b1;
        if (idx_q == 4'd14) raw_rk = {win_q[0], win_q[1], win_q[2], win_q[3]};
        else                raw_rk = {win_q[4], win_q[5], win_q[6], win_q[7]};
        if (rk_yumi_i) begin
          idx_d   = idx_q - 4'd1;
          state_d = (idx_q == 4'd14) ? CALC_A : EMIT_LO;
        end
      end
      CALC_A: begin
        win_d[7] = win_q[7] ^ win_q[6];
        win_d[6] = win_q[6] ^ win_q[5];
        win_d[5] = win_q[5] ^ win_q[4];
        win_d[4] = win_q[4] ^ sub_a;
        win_d[3] = win_q[3] ^ win_q[2];
        win_d[2] = win_q[2] ^ win_q[1];
        win_d[1] = win_q[1] ^ win_q[0];
        state_d  = CALC_B;
      end
      CALC_B: begin
        win_d[0] = win_q[0] ^ sub_b ^ rcon;
        if (r_q != 3'd1) r_d = r_q - 3'd1;
        state_d  = EMIT_HI;
      end
      EMIT_LO: begin
        rk_v_o    = 1'b1;
        raw_rk    = {win_q[0], win_q[1], win_q[2], win_q[3]};
        rk_last_o = (idx_q == 4'd0);
        if (rk_yumi_i) begin
          if (idx_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q - 4'd1;
            state_d = CALC_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rk_idx_o = idx_q;

`ifdef AES_INV_KEY_EQINV_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k as a sum of a, 2a, 4a, 8a.
  function automatic logic [7:0] cmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^
           (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {cmul(a0, 4'd14) ^ cmul(a1, 4'd11) ^ cmul(a2, 4'd13) ^ cmul(a3, 4'd9),
            cmul(a0, 4'd9)  ^ cmul(a1, 4'd14) ^ cmul(a2, 4'd11) ^ cmul(a3, 4'd13),
            cmul(a0, 4'd13) ^ cmul(a1, 4'd9)  ^ cmul(a2, 4'd14) ^ cmul(a3, 4'd11),
            cmul(a0, 4'd11) ^ cmul(a1, 4'd13) ^ cmul(a2, 4'd9)  ^ cmul(a3, 4'd14)};
  endfunction

  // Inner round keys become equivalent-inverse keys; first and last pass through.
  always_comb begin
    if (rk_v_o && (idx_q != 4'd0) && (idx_q != 4'd14)) begin
      rk_o = {inv_mix_col(raw_rk[127:96]), inv_mix_col(raw_rk[95:64]),
              inv_mix_col(raw_rk[63:32]),  inv_mix_col(raw_rk[31:0])};
    end else begin
      rk_o = raw_rk;
    end
  end
`else
  assign rk_o = raw_rk;
`endif

endmodule
